contador_dec_nb: RTL and testbench
==================================

CONTADOR_DEC_NB -- requirements
Module: contador_dec_nb

Interface
REQ-001 Parameter: n, default 8, counter width in bits (legal 2..16).
REQ-002 Parameter: AUTO_RECARGA, default 0, 1 = reload and keep running at terminal count.
REQ-003 Port: i_Clk  input  1  system clock, all state changes on rising edge.
REQ-004 Port: i_Rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: i_Load  input  1  load i_Dato into count and reload register.
REQ-006 Port: i_Dato  input  n  load value, unsigned.
REQ-007 Port: i_Start  input  1  start or resume counting.
REQ-008 Port: i_Stop  input  1  pause counting.
REQ-009 Port: i_Dec  input  1  decrement enable, one step per cycle high.
REQ-010 Port: o_Cta  output  n  current count, registered.
REQ-011 Port: o_Cero  output  1  high when o_Cta == 0, combinational from o_Cta.
REQ-012 Port: o_Fin  output  1  one-cycle terminal-count pulse, registered.
REQ-013 Port: o_Ocupado  output  1  high in RUN or PAUSE, registered-state decode.

Function
REQ-014 The block SHALL implement a four-state FSM: IDLE, RUN, PAUSE, DONE.
REQ-015 The block SHALL hold an n-bit reload register (recarga) written only by i_Load.
REQ-016 i_Load SHALL have highest priority in every state: next cycle o_Cta = i_Dato, recarga = i_Dato, state = IDLE, o_Fin = 0.
REQ-017 IDLE: i_Start with o_Cta != 0 SHALL go to RUN next cycle; i_Start with o_Cta == 0 SHALL be ignored.
REQ-018 RUN: i_Dec=1, i_Stop=0, o_Cta > 1 SHALL decrement o_Cta by 1 next cycle, no wrap.
REQ-019 RUN: i_Dec=1, i_Stop=0, o_Cta == 1, AUTO_RECARGA=0 SHALL give o_Cta = 0, o_Fin = 1 for one cycle, state DONE, all in the same next cycle.
REQ-020 RUN: same condition with AUTO_RECARGA=1 SHALL give o_Cta = recarga, o_Fin = 1 for one cycle, state stays RUN; o_Cta never shows 0.
REQ-021 RUN: i_Dec=0 SHALL hold o_Cta.
REQ-022 RUN: i_Stop=1 SHALL go to PAUSE and hold o_Cta; i_Stop beats i_Dec in the same cycle (no decrement, no o_Fin).
REQ-023 PAUSE: o_Cta frozen; i_Dec ignored; i_Start (i_Stop=0) SHALL return to RUN; i_Start and i_Stop both high SHALL stay in PAUSE.
REQ-024 DONE: o_Cta holds 0; i_Start with recarga != 0 SHALL load o_Cta = recarga and enter RUN next cycle; with recarga == 0 SHALL stay DONE.
REQ-025 i_Start in RUN and i_Stop outside RUN SHALL have no effect.
REQ-026 o_Fin SHALL be high only in the cycle after a terminal decrement; never two consecutive cycles unless recarga == 1 with AUTO_RECARGA=1 and i_Dec held.
REQ-027 Latency from a qualifying input edge to the output change SHALL be exactly one clock.
REQ-028 The decrement SHALL be unsigned n-bit; o_Cta SHALL never underflow past 0.

Reset
REQ-029 i_Rst low SHALL immediately, without a clock edge, force state IDLE, o_Cta = 0, recarga = 0, o_Fin = 0, o_Ocupado = 0, hence o_Cero = 1.
REQ-030 Reset asserted mid-RUN or mid-PAUSE SHALL abort with no o_Fin pulse; after release the block SHALL wait in IDLE for i_Load.
REQ-031 The first rising edge after i_Rst deasserts SHALL be a normal functional edge.

Verification
REQ-032 n=8: i_Load with i_Dato=3, i_Start, i_Dec held -> o_Cta 3,2,1,0; o_Fin one cycle with o_Cta=0; state DONE; o_Ocupado drops the same cycle.
REQ-033 AUTO_RECARGA=1, load 2, start, i_Dec held 6 cycles -> o_Cta 2,1,2,1,2,1; o_Fin high every second cycle; o_Ocupado stays 1.
REQ-034 Load 5, start, 2 decrements, i_Stop together with i_Dec -> o_Cta holds 3 in PAUSE; i_Dec ignored; i_Start resumes 3,2,1,0.
REQ-035 Load 4, start, decrement to 2, assert i_Rst asynchronously between edges -> o_Cta = 0, o_Fin = 0 before the next edge; i_Start after release ignored.
REQ-036 Load 0 then i_Start -> stays IDLE, o_Cero = 1; i_Load and i_Start together with i_Dato=7 -> o_Cta = 7, state IDLE (start ignored).
REQ-037 From DONE with recarga=3, i_Start -> o_Cta = 3, RUN next cycle; i_Load during RUN with i_Dato=9 -> o_Cta = 9, IDLE.

Source files
------------

// File: rtl/contador_dec_nb_if.sv
// rtl/contador_dec_nb_if.sv - control/status bundle for the loadable down-counter
//
// Purpose: groups the counter's command inputs and status outputs so the
// counter and its driver connect through one port.
// Signals:
//   i_Load    load i_Dato into count and reload register
//   i_Dato    n-bit unsigned load value
//   i_Start   start / resume counting
//   i_Stop    pause counting
//   i_Dec     decrement enable, one step per cycle
//   o_Cta     current count (registered)
//   o_Cero    count is zero
//   o_Fin     one-cycle terminal-count pulse
//   o_Ocupado counter is running or paused
// Modports: master drives commands and observes status, slave is the counter.
interface contador_dec_nb_if #(
  parameter int n = 8
);
  logic         i_Load;
  logic [n-1:0] i_Dato;
  logic         i_Start;
  logic         i_Stop;
  logic         i_Dec;
  logic [n-1:0] o_Cta;
  logic         o_Cero;
  logic         o_Fin;
  logic         o_Ocupado;

  modport master (
    output i_Load, i_Dato, i_Start, i_Stop, i_Dec,
    input  o_Cta, o_Cero, o_Fin, o_Ocupado
  );

  modport slave (
    input  i_Load, i_Dato, i_Start, i_Stop, i_Dec,
    output o_Cta, o_Cero, o_Fin, o_Ocupado
  );
endinterface

// File: rtl/contador_dec_nb.sv
// rtl/contador_dec_nb.sv - loadable down-counter with start/stop/pause and optional auto-reload
//
// Purpose: n-bit down-counter controlled by a four-state FSM (IDLE, RUN,
// PAUSE, DONE). A load writes both the count and a reload register; the
// reload register restarts the count from DONE or, with AUTO_RECARGA=1,
// at every terminal count while running.
// Ports:
//   i_Clk  rising-edge clock
//   i_Rst  asynchronous active-low reset
//   bus    contador_dec_nb_if.slave (commands in, count/status out)
// Parameters:
//   n            counter width, 2..16
//   AUTO_RECARGA 1 = reload and keep running at terminal count
module contador_dec_nb #(
  parameter int n            = 8,
  parameter bit AUTO_RECARGA = 1'b0
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  contador_dec_nb_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [n-1:0] UNO = {{(n-1){1'b0}}, 1'b1};

  state_t       state;
  logic [n-1:0] cta;
  logic [n-1:0] recarga;
  logic         fin;
  logic         ocupado;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state   <= IDLE;
      cta     <= '0;
      recarga <= '0;
      fin     <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      fin <= 1'b0;
      if (bus.i_Load) begin
        // Load overrides everything, including a pending start.
        cta     <= bus.i_Dato;
        recarga <= bus.i_Dato;
        state   <= IDLE;
        ocupado <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.i_Start && (cta != '0)) begin
              state   <= RUN;
              ocupado <= 1'b1;
            end
          end
          RUN: begin
            if (bus.i_Stop) begin
              // Stop wins over a same-cycle decrement.
              state <= PAUSE;
            end else if (bus.i_Dec) begin
              if (cta > UNO) begin
                cta <= cta - UNO;
              end else if (cta == UNO) begin
                fin <= 1'b1;
                if (AUTO_RECARGA) begin
                  // Jump straight to the reload value so 0 is never shown.
                  cta <= recarga;
                end else begin
                  cta     <= '0;
                  state   <= DONE;
                  ocupado <= 1'b0;
                end
              end
            end
          end
          PAUSE: begin
            if (bus.i_Start && !bus.i_Stop) begin
              state <= RUN;
            end
          end
          DONE: begin
            if (bus.i_Start && (recarga != '0)) begin
              cta     <= recarga;
              state   <= RUN;
              ocupado <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            ocupado <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_Cta     = cta;
  assign bus.o_Cero    = (cta == '0);
  assign bus.o_Fin     = fin;
  assign bus.o_Ocupado = ocupado;

endmodule

// File: tb/tb_contador_dec_nb.sv
// tb/tb_contador_dec_nb.sv - self-checking bench for contador_dec_nb (both reload modes)
module tb_contador_dec_nb;

  localparam int N = 8;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  typedef struct {
    int cta;
    int rec;
    int mode;
    bit fin;
  } mdl_t;

  typedef struct {
    bit ld;
    int dato;
    bit st;
    bit sp;
    bit dc;
    int exp_cta;
    bit exp_fin;
    bit exp_ocup;
  } vec_t;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  mdl_t m0, m1;
  bit   c_ld, c_st, c_sp, c_dc;
  int   c_dato;

  contador_dec_nb_if #(.n(N)) bus0 ();
  contador_dec_nb_if #(.n(N)) bus1 ();

  contador_dec_nb #(.n(N), .AUTO_RECARGA(1'b0)) dut0 (
    .i_Clk (clk),
    .i_Rst (rst_n),
    .bus   (bus0.slave)
  );

  contador_dec_nb #(.n(N), .AUTO_RECARGA(1'b1)) dut1 (
    .i_Clk (clk),
    .i_Rst (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.cta  = 0;
    r.rec  = 0;
    r.mode = M_IDLE;
    r.fin  = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit auto_r, bit ld, int dato, bit st, bit sp, bit dc);
    mdl_t r = m;
    r.fin = 1'b0;
    if (ld) begin
      r.cta  = dato;
      r.rec  = dato;
      r.mode = M_IDLE;
      return r;
    end
    case (m.mode)
      M_IDLE:  if (st && m.cta != 0) r.mode = M_RUN;
      M_RUN: begin
        if (sp) r.mode = M_PAUSE;
        else if (dc && m.cta > 1) r.cta = m.cta - 1;
        else if (dc && m.cta == 1) begin
          r.fin = 1'b1;
          if (auto_r) r.cta = m.rec;
          else begin
            r.cta  = 0;
            r.mode = M_DONE;
          end
        end
      end
      M_PAUSE: if (st && !sp) r.mode = M_RUN;
      default: if (st && m.rec != 0) begin
        r.cta  = m.rec;
        r.mode = M_RUN;
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_models(input string tag);
    chk({tag, " dut0.cta"},  int'(bus0.o_Cta),     m0.cta);
    chk({tag, " dut0.fin"},  int'(bus0.o_Fin),     int'(m0.fin));
    chk({tag, " dut0.ocup"}, int'(bus0.o_Ocupado), int'(m0.mode == M_RUN || m0.mode == M_PAUSE));
    chk({tag, " dut0.cero"}, int'(bus0.o_Cero),    int'(m0.cta == 0));
    chk({tag, " dut1.cta"},  int'(bus1.o_Cta),     m1.cta);
    chk({tag, " dut1.fin"},  int'(bus1.o_Fin),     int'(m1.fin));
    chk({tag, " dut1.ocup"}, int'(bus1.o_Ocupado), int'(m1.mode == M_RUN || m1.mode == M_PAUSE));
    chk({tag, " dut1.cero"}, int'(bus1.o_Cero),    int'(m1.cta == 0));
  endtask

  task automatic set_in(input bit ld, input int dato, input bit st, input bit sp, input bit dc);
    c_ld = ld; c_dato = dato; c_st = st; c_sp = sp; c_dc = dc;
    bus0.i_Load = ld; bus0.i_Dato = N'(dato); bus0.i_Start = st; bus0.i_Stop = sp; bus0.i_Dec = dc;
    bus1.i_Load = ld; bus1.i_Dato = N'(dato); bus1.i_Start = st; bus1.i_Stop = sp; bus1.i_Dec = dc;
  endtask

  // Called at a falling edge with inputs already applied; advances one clock
  // and compares both counters against the model at the next falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) begin
      m0 = mdl_step(m0, 1'b0, c_ld, c_dato, c_st, c_sp, c_dc);
      m1 = mdl_step(m1, 1'b1, c_ld, c_dato, c_st, c_sp, c_dc);
    end
    @(negedge clk);
    chk_models(tag);
  endtask

  vec_t vecs[$];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    set_in(0, 0, 0, 0, 0);
    m0 = mdl_reset();
    m1 = mdl_reset();

    // Directed sequence for the non-reloading counter: count 3 to 0,
    // restart from DONE, load during RUN, load zero, load with start.
    vecs.push_back('{1, 3, 0, 0, 0, 3, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 3, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 1, 2, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 1, 1, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 3, 0, 1});
    vecs.push_back('{1, 9, 0, 0, 1, 9, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 7, 1, 0, 0, 7, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 7, 0, 0});

    @(negedge clk);
    @(negedge clk);
    chk("reset cta",  int'(bus0.o_Cta),     0);
    chk("reset cero", int'(bus0.o_Cero),    1);
    chk("reset fin",  int'(bus0.o_Fin),     0);
    chk("reset ocup", int'(bus0.o_Ocupado), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      set_in(vecs[i].ld, vecs[i].dato, vecs[i].st, vecs[i].sp, vecs[i].dc);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d cta", i),  int'(bus0.o_Cta),     vecs[i].exp_cta);
      chk($sformatf("vec%0d fin", i),  int'(bus0.o_Fin),     int'(vecs[i].exp_fin));
      chk($sformatf("vec%0d ocup", i), int'(bus0.o_Ocupado), int'(vecs[i].exp_ocup));
    end

    // Auto-reload: load 2, start, hold dec for six cycles.
    set_in(1, 2, 0, 0, 0); tick("ar load");
    set_in(0, 0, 1, 0, 0); tick("ar start");
    chk("ar start cta", int'(bus1.o_Cta), 2);
    for (int k = 1; k <= 6; k++) begin
      set_in(0, 0, 0, 0, 1);
      tick("ar dec");
      chk($sformatf("ar dec%0d cta", k),  int'(bus1.o_Cta),     (k % 2 == 1) ? 1 : 2);
      chk($sformatf("ar dec%0d fin", k),  int'(bus1.o_Fin),     (k % 2 == 0) ? 1 : 0);
      chk($sformatf("ar dec%0d ocup", k), int'(bus1.o_Ocupado), 1);
    end

    // Pause: load 5, two decrements, stop together with dec, then resume.
    set_in(1, 5, 0, 0, 0); tick("pz load");
    set_in(0, 0, 1, 0, 0); tick("pz start");
    set_in(0, 0, 0, 0, 1); tick("pz dec");
    tick("pz dec");
    set_in(0, 0, 0, 1, 1); tick("pz stop");
    chk("pz stop cta", int'(bus0.o_Cta), 3);
    set_in(0, 0, 0, 0, 1); tick("pz dec ignored");
    chk("pz frozen cta", int'(bus0.o_Cta), 3);
    set_in(0, 0, 1, 1, 0); tick("pz start+stop");
    chk("pz start+stop ocup", int'(bus0.o_Ocupado), 1);
    set_in(0, 0, 1, 0, 0); tick("pz resume");
    chk("pz resume cta", int'(bus0.o_Cta), 3);
    set_in(0, 0, 0, 0, 1);
    for (int k = 2; k >= 0; k--) begin
      tick("pz run");
      chk($sformatf("pz run cta%0d", k), int'(bus0.o_Cta), k);
    end
    chk("pz end fin", int'(bus0.o_Fin), 1);

    // Asynchronous reset between edges mid-RUN.
    set_in(1, 4, 0, 0, 0); tick("rs load");
    set_in(0, 0, 1, 0, 0); tick("rs start");
    set_in(0, 0, 0, 0, 1); tick("rs dec");
    tick("rs dec");
    chk("rs pre cta", int'(bus0.o_Cta), 2);
    #2 rst_n = 1'b0;
    #1;
    m0 = mdl_reset();
    m1 = mdl_reset();
    chk("rs async cta0",  int'(bus0.o_Cta),     0);
    chk("rs async cta1",  int'(bus1.o_Cta),     0);
    chk("rs async fin",   int'(bus0.o_Fin),     0);
    chk("rs async ocup",  int'(bus0.o_Ocupado), 0);
    chk("rs async cero",  int'(bus0.o_Cero),    1);
    @(negedge clk);
    chk_models("rs held");
    rst_n = 1'b1;
    set_in(0, 0, 1, 0, 0); tick("rs start ignored");
    chk("rs start ignored ocup", int'(bus0.o_Ocupado), 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      bit ld, st, sp, dc;
      int d;
      ld = ($urandom_range(0, 15) == 0);
      d  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
      st = ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 7) == 0);
      dc = ($urandom_range(0, 3) != 0);
      set_in(ld, d, st, sp, dc);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
